// File: rtl/pkt_router_if.sv
// pkt_router_if: CPU register bus plus packet ingress/egress bundle for pkt_router.
// The master side (CPU and packet source/sink) drives requests; the slave side is the router.
interface pkt_router_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8
);
  logic                        cs;
  logic [ADDR_W-1:0]           addr;
  logic                        rw;
  logic [DATA_W-1:0]           din;
  logic [DATA_W-1:0]           dout;
  logic [DATA_W-1:0]           rxd;
  logic                        rx_vld;
  logic [NUM_PORTS*DATA_W-1:0] txd;
  logic [NUM_PORTS-1:0]        tx_vld;
  logic [NUM_PORTS-1:0]        tx_last;
  logic [NUM_PORTS-1:0]        tx_rdy;

  modport master (
    output cs, addr, rw, din, rxd, rx_vld, tx_rdy,
    input  dout, txd, tx_vld, tx_last
  );

  modport slave (
    input  cs, addr, rw, din, rxd, rx_vld, tx_rdy,
    output dout, txd, tx_vld, tx_last
  );
endinterface

// File: rtl/pkt_router.sv
// pkt_router: routes one ingress byte stream by header to NUM_PORTS first-word-fall-through FIFOs.
// Define PKT_ROUTER_STATS_EN to implement the per-port accepted-packet counters at 0x10+p.
module pkt_router #(
  parameter int DATA_W      = 8,
  parameter int NUM_PORTS   = 4,
  parameter int FIFO_DEPTH  = 16,
  parameter int MAX_PKT_LEN = 8,
  parameter int ADDR_W      = 8
) (
  input logic         clk,
  input logic         rst,
  pkt_router_if.slave bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(MAX_PKT_LEN + 1);
  localparam int HW = ADDR_W - 4;

  typedef enum logic [1:0] {S_SYNC = 2'd0, S_IDLE = 2'd1, S_FWD = 2'd2, S_DROP = 2'd3} state_t;

  state_t                      state_r, state_nxt_s;
  logic [DATA_W-1:0]           stage_r;
  logic [PW-1:0]               dest_r;
  logic [CW-1:0]               beat_cnt_r;
  logic [DATA_W-1:0]           ctrl_r, port_en_r, drop_cnt_r, dout_r, rdata_s;
  logic [DATA_W:0]             mem_r [NUM_PORTS][FIFO_DEPTH];
  logic [LW-1:0]               wr_ptr_r [NUM_PORTS];
  logic [LW-1:0]               rd_ptr_r [NUM_PORTS];
  logic [LW-1:0]               level_s [NUM_PORTS];
  logic [NUM_PORTS-1:0]        vld_s, pop_s, last_s;
  logic [NUM_PORTS*DATA_W-1:0] txd_s;
  logic [PW-1:0]               hdr_port_s;
  logic [LW-1:0]               free_s;
  logic                        accept_s, at_max_s, wr_s, rd_s;
  logic                        hdr_ld_s, stage_ld_s, push_s, push_last_s, drop_inc_s;
  logic [HW-1:0]               addr_hi_s;
  logic [3:0]                  addr_lo_s;

  assign hdr_port_s = bus.rxd[PW-1:0];
  assign free_s     = LW'(FIFO_DEPTH) - level_s[hdr_port_s];
  // A full packet's worth of space is reserved at the header, so the FIFO can never overflow.
  assign accept_s   = ctrl_r[0] && port_en_r[hdr_port_s] && (free_s >= LW'(MAX_PKT_LEN));
  assign at_max_s   = (beat_cnt_r == CW'(MAX_PKT_LEN));
  assign wr_s       = bus.cs && !bus.rw;
  assign rd_s       = bus.cs && bus.rw;
  assign addr_hi_s  = bus.addr[ADDR_W-1:4];
  assign addr_lo_s  = bus.addr[3:0];

  // Ingress FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_SYNC;
    else     state_r <= state_nxt_s;
  end

  // Ingress FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_SYNC:  if (bus.rx_vld) state_nxt_s = S_SYNC; else state_nxt_s = S_IDLE;
      S_IDLE:  if (!bus.rx_vld) state_nxt_s = S_IDLE;
               else if (accept_s) state_nxt_s = S_FWD;
               else state_nxt_s = S_DROP;
      S_FWD:   if (!bus.rx_vld) state_nxt_s = S_IDLE;
               else if (at_max_s) state_nxt_s = S_DROP;
               else state_nxt_s = S_FWD;
      S_DROP:  if (bus.rx_vld) state_nxt_s = S_DROP; else state_nxt_s = S_IDLE;
      default: state_nxt_s = S_SYNC;
    endcase
  end

  // Ingress FSM outputs: staged beat is pushed one beat late so the final one can carry last.
  always_comb begin
    hdr_ld_s    = 1'b0;
    stage_ld_s  = 1'b0;
    push_s      = 1'b0;
    push_last_s = 1'b0;
    drop_inc_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.rx_vld && accept_s) hdr_ld_s = 1'b1;
        else if (bus.rx_vld)        drop_inc_s = 1'b1;
        else                        hdr_ld_s = 1'b0;
      end
      S_FWD: begin
        push_s = 1'b1;
        if (at_max_s || !bus.rx_vld) push_last_s = 1'b1;
        else                         stage_ld_s = 1'b1;
      end
      default: hdr_ld_s = 1'b0;
    endcase
  end

  // Staging register, destination latch and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r    <= '0;
      dest_r     <= '0;
      beat_cnt_r <= '0;
    end else if (hdr_ld_s) begin
      stage_r    <= bus.rxd;
      dest_r     <= hdr_port_s;
      beat_cnt_r <= CW'(1);
    end else if (stage_ld_s) begin
      stage_r    <= bus.rxd;
      beat_cnt_r <= beat_cnt_r + CW'(1);
    end
  end

  // FIFO head view: data and last are forced to zero while a port is empty.
  always_comb begin
    txd_s  = '0;
    last_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      level_s[p] = wr_ptr_r[p] - rd_ptr_r[p];
      vld_s[p]   = (level_s[p] != '0);
      pop_s[p]   = vld_s[p] && bus.tx_rdy[p];
      if (vld_s[p]) begin
        txd_s[p*DATA_W +: DATA_W] = mem_r[p][rd_ptr_r[p][AW-1:0]][DATA_W-1:0];
        last_s[p]                 = mem_r[p][rd_ptr_r[p][AW-1:0]][DATA_W];
      end else begin
        txd_s[p*DATA_W +: DATA_W] = '0;
        last_s[p]                 = 1'b0;
      end
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        wr_ptr_r[p] <= '0;
        rd_ptr_r[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (push_s && (dest_r == PW'(p))) wr_ptr_r[p] <= wr_ptr_r[p] + LW'(1);
        if (pop_s[p])                     rd_ptr_r[p] <= rd_ptr_r[p] + LW'(1);
      end
    end
  end

  // FIFO storage; contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (push_s && (dest_r == PW'(p))) mem_r[p][wr_ptr_r[p][AW-1:0]] <= {push_last_s, stage_r};
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r    <= '0;
      port_en_r <= '0;
    end else if (wr_s) begin
      case (bus.addr)
        ADDR_W'(0): ctrl_r    <= bus.din;
        ADDR_W'(1): port_en_r <= bus.din;
        default:    ctrl_r    <= ctrl_r;
      endcase
    end
  end

  // Saturating drop counter; a CPU write clears it even when a drop lands the same cycle.
  always_ff @(posedge clk) begin
    if (rst)                                                    drop_cnt_r <= '0;
    else if (wr_s && (bus.addr == ADDR_W'(2)))                  drop_cnt_r <= '0;
    else if (drop_inc_s && (drop_cnt_r != {DATA_W{1'b1}}))      drop_cnt_r <= drop_cnt_r + DATA_W'(1);
  end

`ifdef PKT_ROUTER_STATS_EN
  logic [DATA_W-1:0] pkt_cnt_r [NUM_PORTS];

  // Per-port accepted-packet counters, wrapping; CPU clear wins over increment.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst)
        pkt_cnt_r[p] <= '0;
      else if (wr_s && (addr_hi_s == HW'(1)) && (addr_lo_s == 4'(p)))
        pkt_cnt_r[p] <= '0;
      else if (hdr_ld_s && (hdr_port_s == PW'(p)))
        pkt_cnt_r[p] <= pkt_cnt_r[p] + DATA_W'(1);
    end
  end
`endif

  // CPU read decode.
  always_comb begin
    rdata_s = '0;
    if (bus.addr == ADDR_W'(0))      rdata_s = ctrl_r;
    else if (bus.addr == ADDR_W'(1)) rdata_s = port_en_r;
    else if (bus.addr == ADDR_W'(2)) rdata_s = drop_cnt_r;
    else if ((addr_hi_s == HW'(1)) && (addr_lo_s < 4'(NUM_PORTS))) begin
`ifdef PKT_ROUTER_STATS_EN
      rdata_s = pkt_cnt_r[addr_lo_s[PW-1:0]];
`else
      rdata_s = '0;
`endif
    end
    else if ((addr_hi_s == HW'(2)) && (addr_lo_s < 4'(NUM_PORTS)))
      rdata_s = DATA_W'(level_s[addr_lo_s[PW-1:0]]);
    else
      rdata_s = '0;
  end

  // Registered read data, held until the next read.
  always_ff @(posedge clk) begin
    if (rst)       dout_r <= '0;
    else if (rd_s) dout_r <= rdata_s;
  end

  assign bus.dout    = dout_r;
  assign bus.txd     = txd_s;
  assign bus.tx_vld  = vld_s;
  assign bus.tx_last = last_s;
endmodule

// File: tb/tb_pkt_router.sv
// tb_pkt_router: directed bench for pkt_router. A packet-level model predicts every egress beat,
// the FIFO occupancy and the counters; one negedge process checks every valid egress beat.
module tb_pkt_router;
  localparam int DATA_W = 8, NUM_PORTS = 4, FIFO_DEPTH = 16, MAX_PKT_LEN = 8, ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pkt_router_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W)) bus ();

  pkt_router #(
    .DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_PKT_LEN(MAX_PKT_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q [NUM_PORTS][$];
  int         pops [NUM_PORTS];
  logic [7:0] m_ctrl, m_en, m_drop;
  logic [7:0] m_pkt [NUM_PORTS];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Egress checker: every visible beat must equal the head of the model queue for that port.
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (bus.tx_vld[p]) begin
          n_cmp++;
          if (exp_q[p].size() == 0) begin
            n_err++;
            $display("FAIL egress_p%0d: got beat last=%0b data=0x%0h, expected no beat",
                     p, bus.tx_last[p], bus.txd[p*DATA_W +: DATA_W]);
          end else if ({bus.tx_last[p], bus.txd[p*DATA_W +: DATA_W]} !== exp_q[p][0]) begin
            n_err++;
            $display("FAIL egress_p%0d: got last=%0b data=0x%0h, expected last=%0b data=0x%0h",
                     p, bus.tx_last[p], bus.txd[p*DATA_W +: DATA_W], exp_q[p][0][8], exp_q[p][0][7:0]);
          end
          if (bus.tx_rdy[p]) begin
            pops[p]++;
            if (exp_q[p].size() != 0) void'(exp_q[p].pop_front());
          end
        end
      end
    end
  end

  function automatic logic [7:0] pkt_cnt_exp(input int p);
`ifdef PKT_ROUTER_STATS_EN
    return m_pkt[p];
`else
    return 8'h00;
`endif
  endfunction

  function automatic bit pending();
    for (int p = 0; p < NUM_PORTS; p++) if (exp_q[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM_PORTS; p++) begin
      exp_q[p].delete();
      m_pkt[p] = 8'h00;
    end
    m_ctrl = 8'h00;
    m_en   = 8'h00;
    m_drop = 8'h00;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    bus.cs = 1'b0;
    if (a == 8'h00) m_ctrl = d;
    else if (a == 8'h01) m_en = d;
    else if (a == 8'h02) m_drop = 8'h00;
    else if (a >= 8'h10 && a < 8'h10 + 8'(NUM_PORTS)) m_pkt[a - 8'h10] = 8'h00;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.cs = 1'b0;
    d = bus.dout;
  endtask

  // Packet-level rule: accept iff enabled, port enabled and a whole max packet fits.
  task automatic model_header(input logic [7:0] hdr, input int len, input logic [7:0] seed);
    int p, n;
    p = int'(hdr[1:0]);
    if (m_ctrl[0] && m_en[p] && (FIFO_DEPTH - exp_q[p].size() >= MAX_PKT_LEN)) begin
      n = (len < MAX_PKT_LEN) ? len : MAX_PKT_LEN;
      for (int i = 0; i < n; i++)
        exp_q[p].push_back({(i == n - 1) ? 1'b1 : 1'b0, (i == 0) ? hdr : seed + 8'(i)});
      m_pkt[p] = m_pkt[p] + 8'd1;
    end else if (m_drop != 8'hFF) begin
      m_drop = m_drop + 8'd1;
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int len, input logic [7:0] seed);
    model_header(hdr, len, seed);
    for (int i = 0; i < len; i++) begin
      bus.rxd = (i == 0) ? hdr : seed + 8'(i);
      bus.rx_vld = 1'b1;
      @(posedge clk); #1;
    end
    bus.rx_vld = 1'b0;
    bus.rxd = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (pending() && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++;
    if (pending()) begin
      n_err++;
      $display("FAIL %s: got beats still pending after 200 cycles, expected all drained", name);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int         base [NUM_PORTS];
    bus.cs = 1'b0; bus.rw = 1'b1; bus.addr = 8'h00; bus.din = 8'h00;
    bus.rxd = 8'h00; bus.rx_vld = 1'b0; bus.tx_rdy = 4'hF;
    for (int p = 0; p < NUM_PORTS; p++) pops[p] = 0;
    model_clear();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", bus.dout, 8'h00);
    check("rst_tx_vld", bus.tx_vld, 4'h0);
    check("rst_tx_last", bus.tx_last, 4'h0);
    check("rst_txd", bus.txd, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    cpu_read(8'h00, rd); check("rst_ctrl", rd, 8'h00);
    cpu_read(8'h02, rd); check("rst_drop", rd, 8'h00);

    // Basic forward: hdr 0x02 -> port 2, four beats.
    cpu_write(8'h00, 8'h01);
    cpu_write(8'h01, 8'h0F);
    cpu_read(8'h01, rd); check("port_en_rb", rd, 8'h0F);
    for (int p = 0; p < NUM_PORTS; p++) base[p] = pops[p];
    send_pkt(8'h02, 4, 8'hA0);
    wait_drain("t1_drain");
    check("t1_port2_beats", pops[2] - base[2], 4);
    check("t1_model_pkt2", m_pkt[2], 8'd1);
    cpu_read(8'h12, rd); check("t1_pkt_cnt2", rd, pkt_cnt_exp(2));
    cpu_read(8'h22, rd); check("t1_level2", rd, 8'h00);

    // Disabled port: hdr 0x06 with port 2 masked off.
    cpu_write(8'h02, 8'h00);
    cpu_write(8'h01, 8'h0B);
    for (int p = 0; p < NUM_PORTS; p++) base[p] = pops[p];
    send_pkt(8'h06, 3, 8'hB0);
    repeat (5) @(posedge clk);
    #1;
    check("t2_no_beats", (pops[0] - base[0]) + (pops[1] - base[1]) + (pops[2] - base[2]) + (pops[3] - base[3]), 0);
    check("t2_model_drop", m_drop, 8'd1);
    cpu_read(8'h02, rd); check("t2_drop_cnt", rd, 8'd1);

    // Backpressure: two 8-beat packets fill port 1, the third is dropped.
    cpu_write(8'h01, 8'h0F);
    cpu_write(8'h02, 8'h00);
    bus.tx_rdy = 4'b1101;
    for (int p = 0; p < NUM_PORTS; p++) base[p] = pops[p];
    send_pkt(8'h01, 8, 8'h10);
    send_pkt(8'h05, 8, 8'h20);
    send_pkt(8'h09, 8, 8'h30);
    check("t3_model_q1", exp_q[1].size(), 16);
    cpu_read(8'h21, rd); check("t3_level1", rd, 8'd16);
    cpu_read(8'h02, rd); check("t3_drop_cnt", rd, m_drop);
    check("t3_model_drop", m_drop, 8'd1);
    cpu_read(8'h11, rd); check("t3_pkt_cnt1", rd, pkt_cnt_exp(1));
    bus.tx_rdy = 4'hF;
    wait_drain("t3_drain");
    check("t3_port1_beats", pops[1] - base[1], 16);

    // Oversized packet truncated to MAX_PKT_LEN, then a normal packet after the gap.
    for (int p = 0; p < NUM_PORTS; p++) base[p] = pops[p];
    send_pkt(8'h04, 10, 8'hC0);
    send_pkt(8'h08, 4, 8'hD0);
    wait_drain("t4_drain");
    check("t4_port0_beats", pops[0] - base[0], 12);
    cpu_read(8'h02, rd); check("t4_trunc_no_drop", rd, 8'd1);

    // Reset mid-packet, released while rx_vld is still high.
    model_header(8'h00, 3, 8'hE0);
    bus.rx_vld = 1'b1;
    bus.rxd = 8'h00; @(posedge clk); #1;
    bus.rxd = 8'hE1; @(posedge clk); #1;
    bus.rxd = 8'hE2; @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    bus.rxd = 8'hE3;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rxd = 8'h01;
    cpu_write(8'h00, 8'h01);
    cpu_write(8'h01, 8'h0F);
    bus.rxd = 8'hE5; @(posedge clk); #1;
    bus.rx_vld = 1'b0; bus.rxd = 8'h00;
    @(posedge clk); #1;
    for (int p = 0; p < NUM_PORTS; p++) base[p] = pops[p];
    send_pkt(8'h03, 3, 8'hF0);
    wait_drain("t5_drain");
    check("t5_port3_beats", pops[3] - base[3], 3);
    check("t5_port1_beats", pops[1] - base[1], 0);
    cpu_read(8'h02, rd); check("t5_drop_cnt", rd, 8'h00);

    // CPU clear and drop in the same cycle: the clear wins.
    cpu_write(8'h01, 8'h0E);
    bus.rxd = 8'h04; bus.rx_vld = 1'b1;
    bus.cs = 1'b1; bus.rw = 1'b0; bus.addr = 8'h02; bus.din = 8'h00;
    @(posedge clk); #1;
    bus.cs = 1'b0;
    bus.rxd = 8'h44; @(posedge clk); #1;
    bus.rx_vld = 1'b0; bus.rxd = 8'h00;
    @(posedge clk); #1;
    cpu_read(8'h02, rd); check("t6_clear_wins", rd, 8'h00);
    send_pkt(8'h08, 2, 8'h50);
    cpu_read(8'h02, rd); check("t6_drop_after", rd, 8'd1);

    // Saturation of the drop counter and unmapped accesses.
    for (int i = 0; i < 260; i++) send_pkt(8'h00, 1, 8'h00);
    check("t7_model_sat", m_drop, 8'hFF);
    cpu_read(8'h02, rd); check("t7_drop_sat", rd, 8'hFF);
    cpu_write(8'h05, 8'h5A);
    cpu_read(8'h05, rd); check("t7_unmapped_05", rd, 8'h00);
    cpu_read(8'h30, rd); check("t7_unmapped_30", rd, 8'h00);
    check("t7_idle_vld", bus.tx_vld, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
